// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: shared size encodings, FSM states and default geometry
package mem_access_unit_pkg;
  localparam int DEF_MEM_WORDS = 128;
  localparam int DEF_ADDR_W = 9;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    return (size == SZ_HALF && off[0]) || (size == SZ_WORD && off != 2'b00) || size == 2'b11;
  endfunction
endpackage

// File: rtl/mau_lane_align.sv
// mau_lane_align: store lane merge and load lane extract/extend
module mau_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] merged,
  output logic [31:0] load_data
);
  logic [7:0] rbyte;
  logic [15:0] rhalf;
  // replace only the addressed lanes of the fetched word; pick and extend the addressed lanes on load
  always_comb begin
    merged = rdata;
    if (size == SZ_WORD) merged = wdata;
    else if (size == SZ_HALF && off[1]) merged[31:16] = wdata[15:0];
    else if (size == SZ_HALF) merged[15:0] = wdata[15:0];
    else merged[{off, 3'b000} +: 8] = wdata[7:0];
    rbyte = rdata[{off, 3'b000} +: 8];
    rhalf = off[1] ? rdata[31:16] : rdata[15:0];
    load_data = size == SZ_WORD ? rdata :
                size == SZ_HALF ? {{16{~is_unsigned & rhalf[15]}}, rhalf} :
                                  {{24{~is_unsigned & rbyte[7]}}, rbyte};
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store sequencer with sub-word read-modify-write
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int MEM_WORDS = DEF_MEM_WORDS,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_misalign,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);
  state_t state, next_state;
  logic [1:0] off_q, size_q;
  logic uns_q, we_q, accept, mis, unused_bits;
  logic [31:0] wdata_q, merged, load_data;
  assign req_ready = state == IDLE;
  assign accept = req_valid && req_ready;
  assign mis = misaligned(req_size, req_addr[1:0]);
  assign unused_bits = ^{req_addr[31:ADDR_W+2], 1'(MEM_WORDS)};
  mau_lane_align u_align (
    .size(size_q),
    .off(off_q),
    .is_unsigned(uns_q),
    .wdata(wdata_q),
    .rdata(mem_rdata),
    .merged(merged),
    .load_data(load_data)
  );
  // misaligned goes straight to RESP; word stores skip the read; sub-word stores read then write
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (req_valid) next_state = mis ? RESP : (req_we && req_size == SZ_WORD) ? WRITE : READ;
      READ: next_state = we_q ? WRITE : RESP;
      WRITE: next_state = RESP;
      default: next_state = IDLE;
    endcase
  end
  // state plus memory enables registered from next state so they are clean flop outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      MemRead <= 1'b0;
      MemWrite <= 1'b0;
    end else begin
      state <= next_state;
      MemRead <= next_state == READ;
      MemWrite <= next_state == WRITE;
    end
  end
  // latch the request at acceptance so later input changes are ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      off_q <= '0;
      size_q <= '0;
      uns_q <= 1'b0;
      we_q <= 1'b0;
      wdata_q <= '0;
    end else if (accept) begin
      off_q <= req_addr[1:0];
      size_q <= req_size;
      uns_q <= req_unsigned;
      we_q <= req_we;
      wdata_q <= req_wdata;
    end
  end
  // memory address/data held in flops so they stay stable across each enable cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr <= '0;
      mem_wdata <= '0;
    end else begin
      if (accept) mem_addr <= req_addr[ADDR_W+1:2];
      if (accept && req_we && req_size == SZ_WORD) mem_wdata <= req_wdata;
      if (state == READ && we_q) mem_wdata <= merged;
    end
  end
  // one-cycle response pulse; data and misalign flag hold until the next response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_misalign <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= next_state == RESP;
      if (next_state == RESP) begin
        resp_misalign <= state == IDLE;
        resp_rdata <= (state == READ && !we_q) ? load_data : '0;
      end
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench with directed load/store vectors
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;
  logic clk = 0, rst_n = 0, req_valid = 0, req_we = 0, req_unsigned = 0;
  logic [1:0] req_size = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic req_ready, resp_valid, resp_misalign, MemRead, MemWrite;
  logic [31:0] resp_rdata, mem_wdata, mem_rdata;
  logic [8:0] mem_addr;
  logic [31:0] mem [0:127];
  int total = 0, bad = 0, cyc = 0, rd_cnt = 0, exp_reads = 0, last_acc = 0, a1;
  typedef struct {logic [31:0] rd; logic mis; int lat; int acc;} resp_t;
  typedef struct {logic [8:0] a; logic [31:0] d;} wr_t;
  resp_t exp_q[$];
  wr_t wr_q[$];

  mem_access_unit dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_misalign(resp_misalign), .MemRead(MemRead),
    .MemWrite(MemWrite), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (MemWrite) mem[mem_addr[6:0]] <= mem_wdata;
  assign mem_rdata = mem[mem_addr[6:0]];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] er, input logic em, input int lat,
                       input int nrd, input logic ew, input logic [8:0] wa, input logic [31:0] wdx);
    int n = 0;
    req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd; req_valid = 1;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("accept_timeout", 0, 1);
    exp_q.push_back('{er, em, lat, cyc});
    if (ew) wr_q.push_back('{wa, wdx});
    exp_reads += nrd;
    last_acc = cyc;
    @(negedge clk);
  endtask

  always @(negedge clk) begin : mon
    resp_t e;
    wr_t w;
    if (rst_n) begin
      chk("rd_wr_exclusive", {31'b0, MemRead & MemWrite}, 0);
      if (MemRead) rd_cnt++;
      if (MemWrite) begin
        if (wr_q.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          w = wr_q.pop_front();
          chk("wr_addr", {23'b0, mem_addr}, {23'b0, w.a});
          chk("wr_data", mem_wdata, w.d);
        end
      end
      if (resp_valid) begin
        if (exp_q.size() == 0) chk("unexpected_resp", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("resp_rdata", resp_rdata, e.rd);
          chk("resp_misalign", {31'b0, resp_misalign}, {31'b0, e.mis});
          chk("resp_latency", cyc - e.acc, e.lat);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 0;
    mem[4] = 32'h11223344;
    mem[8] = 32'h80F07F01;
    mem[12] = 32'h55667788;
    #1;
    chk("rst_memread", {31'b0, MemRead}, 0);
    chk("rst_memwrite", {31'b0, MemWrite}, 0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 0);
    chk("rst_resp_misalign", {31'b0, resp_misalign}, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_mem_addr", {23'b0, mem_addr}, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("ready_after_reset", {31'b0, req_ready}, 1);
    issue(1, SZ_BYTE, 0, 32'h011, 32'h000000AA, 0, 0, 3, 1, 1, 9'd4, 32'h1122AA44);
    issue(0, SZ_WORD, 0, 32'h010, 0, 32'h1122AA44, 0, 2, 1, 0, 0, 0);
    issue(1, SZ_WORD, 0, 32'h010, 32'hDEADBEEF, 0, 0, 2, 0, 1, 9'd4, 32'hDEADBEEF);
    issue(0, SZ_WORD, 0, 32'h010, 0, 32'hDEADBEEF, 0, 2, 1, 0, 0, 0);
    issue(0, SZ_BYTE, 0, 32'h022, 0, 32'hFFFFFFF0, 0, 2, 1, 0, 0, 0);
    issue(0, SZ_HALF, 1, 32'h022, 0, 32'h000080F0, 0, 2, 1, 0, 0, 0);
    issue(0, SZ_HALF, 0, 32'h020, 0, 32'h00007F01, 0, 2, 1, 0, 0, 0);
    issue(0, SZ_BYTE, 1, 32'h023, 0, 32'h00000080, 0, 2, 1, 0, 0, 0);
    issue(0, SZ_BYTE, 0, 32'h021, 0, 32'h0000007F, 0, 2, 1, 0, 0, 0);
    issue(0, SZ_HALF, 0, 32'h013, 0, 0, 1, 1, 0, 0, 0, 0);
    issue(1, SZ_WORD, 0, 32'h016, 32'h12345678, 0, 1, 1, 0, 0, 0, 0);
    issue(0, 2'b11, 0, 32'h020, 0, 0, 1, 1, 0, 0, 0, 0);
    issue(1, SZ_HALF, 0, 32'h022, 32'hFFFFBEEF, 0, 0, 3, 1, 1, 9'd8, 32'hBEEF7F01);
    issue(0, SZ_WORD, 0, 32'h020, 0, 32'hBEEF7F01, 0, 2, 1, 0, 0, 0);
    issue(1, SZ_BYTE, 0, 32'h027, 32'h1234565A, 0, 0, 3, 1, 1, 9'd9, 32'h5A000000);
    issue(0, SZ_HALF, 1, 32'h026, 0, 32'h00005A00, 0, 2, 1, 0, 0, 0);
    req_valid = 0;
    repeat (6) @(negedge clk);
    chk("rdata_hold", resp_rdata, 32'h00005A00);
    req_we = 1; req_size = SZ_BYTE; req_addr = 32'h030; req_wdata = 32'hCC; req_valid = 1;
    @(negedge clk);
    req_valid = 0;
    chk("abort_in_read", {31'b0, MemRead}, 1);
    exp_reads++;
    #2 rst_n = 0;
    #1;
    chk("abort_memread", {31'b0, MemRead}, 0);
    chk("abort_memwrite", {31'b0, MemWrite}, 0);
    chk("abort_resp_valid", {31'b0, resp_valid}, 0);
    chk("abort_resp_rdata", resp_rdata, 0);
    chk("abort_mem_addr", {23'b0, mem_addr}, 0);
    chk("abort_mem_wdata", mem_wdata, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("ready_after_abort", {31'b0, req_ready}, 1);
    issue(0, SZ_WORD, 0, 32'h030, 0, 32'h55667788, 0, 2, 1, 0, 0, 0);
    issue(1, SZ_WORD, 0, 32'h804, 32'h12345678, 0, 0, 2, 0, 1, 9'd1, 32'h12345678);
    a1 = last_acc;
    issue(0, SZ_WORD, 0, 32'h004, 0, 32'h12345678, 0, 2, 1, 0, 0, 0);
    chk("b2b_gap", last_acc - a1, 3);
    req_valid = 0;
    repeat (6) @(negedge clk);
    chk("resp_q_empty", exp_q.size(), 0);
    chk("wr_q_empty", wr_q.size(), 0);
    chk("read_cycles", rd_cnt, exp_reads);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
